// File: rtl/path_read_buffer_pkg.sv
// Shared definitions for the DRAM read-path buffer.
//   pathState_t    : sequencing states of one path (IDLE/FILL/STREAM/DRAIN)
//   pathCntWidth() : width of count/length fields for a given depth
//   clampLen()     : maps a requested path length onto the legal range 1..Depth
package path_read_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } pathState_t;

  // Count and length fields must be able to hold the value Depth itself.
  function automatic int pathCntWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A length of zero, or one larger than the buffer, means "a full buffer".
  function automatic int unsigned clampLen(input int unsigned pathLen,
                                           input int unsigned depth);
    return ((pathLen == 0) || (pathLen > depth)) ? depth : pathLen;
  endfunction

endpackage

// File: rtl/path_read_buffer_ram.sv
// path_buffer_ram: Depth x Width storage for the read-path buffer.
// Synchronous write; registered read whose address is the read pointer the
// buffer will hold after this cycle, so the head entry is always presented
// (first-word-fall-through) one cycle after it is written or popped to.
// A write to the address being read is bypassed into the read register.
// Ports:
//   Clock, Reset        clock, asynchronous active-low reset (read register)
//   WrEn/WrAddr/WrData  write port
//   RdAddr              next-cycle read address
//   RdData              registered head-of-buffer data
module path_buffer_ram #(
  parameter int Width = 512,
  parameter int Depth = 64,
  parameter int AddrW = 6
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             WrEn,
  input  logic [AddrW-1:0] WrAddr,
  input  logic [Width-1:0] WrData,
  input  logic [AddrW-1:0] RdAddr,
  output logic [Width-1:0] RdData
);

  // Plain array with a registered read: small depths infer distributed RAM,
  // larger ones block RAM.
  logic [Width-1:0] mem [Depth];

  always_ff @(posedge Clock) begin
    if (WrEn) mem[WrAddr] <= WrData;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      RdData <= '0;
    end else if (WrEn && (WrAddr == RdAddr)) begin
      RdData <= WrData;
    end else begin
      RdData <= mem[RdAddr];
    end
  end

endmodule

// File: rtl/path_read_buffer.sv
// path_read_buffer: DRAM read-path buffer feeding the ORAM backend.
// Accepts one path of bursts at a time; a path is either streamed (bursts
// forwarded as they land) or held (released only after the whole path has
// landed). DRAM cannot be stalled, so bursts arriving while InReady is low
// are dropped and flagged in the sticky Overflow bit.
//
// Handshake: upstream has no back-pressure; a burst is written when
// InValid & InReady. Downstream pops the head on OutValid & OutReady;
// OutData is stable while OutValid & ~OutReady.
//
// Ports:
//   Clock, Reset       clock, asynchronous active-low reset
//   PathLen, HoldPath  length (0 or >Depth means Depth) and mode of the next
//                      path, sampled on its first accepted burst
//   InData, InValid    DRAM read burst
//   InReady            current path still accepts bursts
//   OutData, OutValid, OutReady  head-of-buffer output
//   Count              occupancy in bursts
//   PathDone           pulse on the pop of the path's last burst
//   Overflow           sticky: a burst arrived while InReady was 0
//   DbgState           current sequencing state
module path_read_buffer
  import path_read_buffer_pkg::*;
#(
  parameter int Width = 512,
  parameter int Depth = 64,
  localparam int CntW = pathCntWidth(Depth)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [CntW-1:0]  PathLen,
  input  logic             HoldPath,
  input  logic [Width-1:0] InData,
  input  logic             InValid,
  output logic             InReady,
  output logic [Width-1:0] OutData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [CntW-1:0]  Count,
  output logic             PathDone,
  output logic             Overflow,
  output pathState_t       DbgState
);

  localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  pathState_t      state;
  logic [AddrW-1:0] wrPtr, rdPtr, rdAddrNext;
  logic [CntW-1:0]  len, inCnt, outCnt, count;
  logic [CntW-1:0]  lenClamped;
  logic             inReadyInt, outValidInt, push, pop, lastPop;

  assign lenClamped  = CntW'(clampLen(32'(PathLen), Depth));

  assign inReadyInt  = (state == IDLE) ||
                       (((state == FILL) || (state == STREAM)) && (inCnt < len));
  assign outValidInt = ((state == STREAM) || (state == DRAIN)) && (count != '0);
  assign push        = InValid && inReadyInt;
  assign pop         = outValidInt && OutReady;
  // Pops are only possible in STREAM/DRAIN, where len is already latched.
  assign lastPop     = pop && (outCnt == (len - CntW'(1)));

  // Pointers wrap naturally since Depth is a power of two.
  assign rdAddrNext  = pop ? (rdPtr + AddrW'(1)) : rdPtr;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      wrPtr    <= '0;
      rdPtr    <= '0;
      len      <= '0;
      inCnt    <= '0;
      outCnt   <= '0;
      count    <= '0;
      Overflow <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + AddrW'(1);
      if (pop)  rdPtr <= rdPtr + AddrW'(1);

      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase

      if (InValid && !inReadyInt) Overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (push) begin
            len   <= lenClamped;
            inCnt <= CntW'(1);
            if (!HoldPath)                   state <= STREAM;
            else if (lenClamped == CntW'(1)) state <= DRAIN;
            else                             state <= FILL;
          end
        end
        FILL: begin
          if (push) begin
            inCnt <= inCnt + CntW'(1);
            if ((inCnt + CntW'(1)) == len) state <= DRAIN;
          end
        end
        STREAM, DRAIN: begin
          // The last pop implies every burst has landed, so it never
          // coincides with a push.
          if (push) inCnt <= inCnt + CntW'(1);
          if (lastPop) begin
            state  <= IDLE;
            inCnt  <= '0;
            outCnt <= '0;
          end else if (pop) begin
            outCnt <= outCnt + CntW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  path_buffer_ram #(
    .Width(Width),
    .Depth(Depth),
    .AddrW(AddrW)
  ) u_ram (
    .Clock (Clock),
    .Reset (Reset),
    .WrEn  (push),
    .WrAddr(wrPtr),
    .WrData(InData),
    .RdAddr(rdAddrNext),
    .RdData(OutData)
  );

  assign InReady  = inReadyInt;
  assign OutValid = outValidInt;
  assign Count    = count;
  assign PathDone = lastPop;
  assign DbgState = state;

endmodule

// File: tb/tb_path_read_buffer.sv
module tb_path_read_buffer;
  import path_read_buffer_pkg::*;

  localparam int WIDTH = 512;
  localparam int DEPTH = 64;
  localparam int CNTW  = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk;
  logic Reset;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [CNTW-1:0]  PathLen;
  logic             HoldPath;
  logic [WIDTH-1:0] InData;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] OutData;
  logic             OutValid;
  logic             OutReady;
  logic [CNTW-1:0]  Count;
  logic             PathDone;
  logic             Overflow;
  pathState_t       dbgState;

  path_read_buffer #(.Width(WIDTH), .Depth(DEPTH)) dut (
    .Clock   (clk),
    .Reset   (Reset),
    .PathLen (PathLen),
    .HoldPath(HoldPath),
    .InData  (InData),
    .InValid (InValid),
    .InReady (InReady),
    .OutData (OutData),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .Count   (Count),
    .PathDone(PathDone),
    .Overflow(Overflow),
    .DbgState(dbgState)
  );

  // ---------------- reference model / scoreboard ----------------
  // Entry = {is_last_of_path, data}
  logic [WIDTH:0] exp_q[$];
  int  errors = 0;
  int  checks = 0;
  bit  pathActive = 0;  // a path has started and its last burst is not yet popped
  bit  doneFlag   = 0;  // last burst popped; buffer returns to idle one cycle later
  bit  mHold = 0;
  int  mLen  = 0;
  int  acc   = 0;       // bursts accepted in the current path
  bit  mOvf  = 0;
  int  readyPct = 100;
  bit  expValid, expReady;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] randWord();
    logic [WIDTH-1:0] w;
    for (int k = 0; k < WIDTH / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // Called at the clock edge on which a driven burst is sampled.
  task automatic modelWrite(input logic [WIDTH-1:0] d);
    if (!pathActive) begin
      int pl;
      pl = int'(PathLen);
      pathActive = 1;
      mLen  = (pl == 0 || pl > DEPTH) ? DEPTH : pl;
      mHold = HoldPath;
      acc   = 0;
    end
    if (acc < mLen) begin
      acc++;
      exp_q.push_back({(acc == mLen), d});
    end else begin
      mOvf = 1;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [WIDTH:0] head;
    if (Reset) begin
      if (doneFlag) begin
        pathActive = 0;
        doneFlag   = 0;
      end
      expValid = (exp_q.size() != 0) && (!mHold || (acc == mLen));
      expReady = !pathActive || (acc < mLen);
      check("count", WIDTH'(Count), WIDTH'(exp_q.size()));
      check("out_valid", WIDTH'(OutValid), WIDTH'(expValid));
      check("in_ready", WIDTH'(InReady), WIDTH'(expReady));
      check("overflow", WIDTH'(Overflow), WIDTH'(mOvf));
      if (OutValid && exp_q.size() != 0) begin
        head = exp_q[0];
        check("out_data", OutData, head[WIDTH-1:0]);
        if (OutReady) begin
          void'(exp_q.pop_front());
          check("path_done", WIDTH'(PathDone), WIDTH'(head[WIDTH]));
          if (head[WIDTH]) doneFlag = 1;
        end else begin
          check("path_done_stall", WIDTH'(PathDone), '0);
        end
      end else begin
        check("path_done_idle", WIDTH'(PathDone), '0);
      end
    end
  end

  // ---------------- consumer ----------------
  initial begin
    OutReady = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      OutReady = ($urandom_range(99, 0) < readyPct);
    end
  end

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic sendPath(input int pathLen, input bit hold, input int n,
                          input int gapMax, input bit seqData);
    PathLen  = CNTW'(pathLen);
    HoldPath = hold;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gapMax, 0)) begin
        InValid = 1'b0;
        @(posedge clk);
        #1;
      end
      InValid = 1'b1;
      InData  = seqData ? WIDTH'(i) : randWord();
      @(posedge clk);
      modelWrite(InData);
      #1;
      // Length and mode must be ignored once a path has started.
      PathLen  = CNTW'($urandom);
      HoldPath = 1'($urandom);
    end
    InValid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int c;
    c = 0;
    while ((pathActive || exp_q.size() != 0) && c < budget) begin
      @(posedge clk);
      c++;
    end
    checks++;
    if (pathActive || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d_left required=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic resetChecks();
    check("rst_count", WIDTH'(Count), '0);
    check("rst_out_valid", WIDTH'(OutValid), '0);
    check("rst_path_done", WIDTH'(PathDone), '0);
    check("rst_overflow", WIDTH'(Overflow), '0);
    check("rst_in_ready", WIDTH'(InReady), WIDTH'(1));
  endtask

  task automatic clearModel();
    exp_q.delete();
    pathActive = 0;
    doneFlag   = 0;
    acc  = 0;
    mLen = 0;
    mHold = 0;
    mOvf = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    Reset = 1'b1;
    InValid = 1'b0;
    InData = '0;
    PathLen = '0;
    HoldPath = 1'b0;
    #2 Reset = 1'b0;
    #1 resetChecks();
    repeat (3) @(posedge clk);
    #1 Reset = 1'b1;
    @(posedge clk);
    #1;

    // 1: streaming, sequential data, back-to-back
    readyPct = 100;
    sendPath(48, 0, 48, 0, 1);
    waitIdle(300);

    // 2: hold mode with random gaps
    sendPath(48, 1, 48, 3, 0);
    waitIdle(300);

    // 3: back-pressure while draining, and in streaming
    readyPct = 50;
    sendPath(48, 1, 48, 0, 0);
    waitIdle(400);
    sendPath(30, 0, 30, 2, 0);
    waitIdle(400);

    // 4: overrun in a 4-burst path
    readyPct = 100;
    sendPath(4, 1, 6, 0, 0);
    waitIdle(100);
    check("overflow_sticky", WIDTH'(Overflow), WIDTH'(1));

    // 5: length clamp, full buffer, pointer wrap, single-burst hold path
    sendPath(0, 1, DEPTH, 0, 0);
    waitIdle(400);
    readyPct = 50;
    sendPath(DEPTH + 5, 0, DEPTH, 1, 0);
    waitIdle(600);
    readyPct = 100;
    sendPath(1, 1, 1, 0, 0);
    waitIdle(50);

    // random paths
    for (int p = 0; p < 6; p++) begin
      int l;
      l = $urandom_range(DEPTH, 1);
      readyPct = $urandom_range(100, 30);
      sendPath(l, 1'($urandom), l, $urandom_range(2, 0), 0);
      waitIdle(1000);
    end

    // 6: reset in the middle of a hold-mode fill
    readyPct = 100;
    sendPath(48, 1, 10, 0, 0);
    #2 Reset = 1'b0;
    #1 resetChecks();
    clearModel();
    repeat (2) @(posedge clk);
    #3 Reset = 1'b1;
    @(posedge clk);
    #1;
    sendPath(48, 0, 48, 1, 0);
    waitIdle(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
